uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  UART receive engine driven by the 16x baud enable from the UART clock generator.
//  Detects start bit, samples mid-bit, deserialises 7/8 data bits LSB first, checks optional parity and stop bit.
//  Presents a byte plus status flags to the RS232 channel controller via a ready/read handshake.
//  Single clock domain clk_sys; rx is asynchronous and is synchronised internally.
// PARAMETERS
//  SYNC_STAGES  2  flops in rx synchroniser (>=2)
//  MID_SAMPLE   7  baud_clock tick index (0..15) within the start bit at which the start bit is confirmed
// PORTS
//  clk_sys       in   1  system clock
//  rst_sys_n     in   1  asynchronous active-low reset
//  baud_clock    in   1  16x-baud one-cycle enable pulse
//  bit8          in   1  1=8 data bits, 0=7 data bits
//  parity_en     in   1  1=parity bit present after data
//  odd_n_even    in   1  1=odd parity, 0=even parity
//  rx            in   1  serial input, idle high, asynchronous
//  read_rx_byte  in   1  one-cycle pulse: consumer has taken rx_data
//  rx_data       out  8  received byte; bit7=0 in 7-bit mode
//  rx_ready      out  1  byte valid, held until read_rx_byte
//  parity_err    out  1  parity error on last stored byte
//  framing_err   out  1  stop bit sampled low on last stored byte
//  overflow      out  1  byte stored while rx_ready was already set
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, sync flops=1, counters 0. Reset mid-frame discards the frame.
//  rx_s = rx after SYNC_STAGES flops. FSM advances only on cycles with baud_clock=1; tick counter samp_cnt 4b.
//  IDLE:   rx_s=0 -> START, samp_cnt=0, latch bit8/parity_en/odd_n_even for the frame.
//  START:  samp_cnt++ per tick; at samp_cnt==MID_SAMPLE: rx_s=0 -> DATA, samp_cnt=0, bit_cnt=0; rx_s=1 -> IDLE (glitch reject).
//  DATA:   sample rx_s at samp_cnt==15 (wrap to 0), shift into shreg LSB first; after bit 6 (7-bit) or 7 (8-bit) -> PARITY if parity_en else STOP.
//  PARITY: sample at samp_cnt==15; perr = ^data ^ rx_s ^ odd_n_even (latched values) -> STOP.
//  STOP:   sample at samp_cnt==15 (mid stop bit) -> store, -> IDLE same tick; next start detect possible next tick.
//  Store (one clk after the stop-sample tick edge, i.e. registered): rx_data=data (7-bit right-aligned, bit7=0);
//   rx_ready=1; parity_err=perr (0 if parity disabled); framing_err=~rx_s; overflow=1 if rx_ready=1 and no read_rx_byte that cycle.
//  Overflow: new byte overwrites rx_data; overflow sticky until read.
//  read_rx_byte: clears rx_ready, parity_err, framing_err, overflow next clk; ignored if rx_ready=0.
//  Read and store same cycle: store wins -> rx_ready=1, new flags, overflow=0.
//  Framing error with rx held low (break): after store, IDLE sees rx_s=0 and restarts; break yields repeated 0x00 frames with framing_err.
//  Config inputs changed mid-frame take effect on next frame only.
//  No dependence on baud_clock period beyond >=2 clk_sys cycles between pulses.
// TESTING
//  8N1, 0xA5, baud_clock every 4 clk -> rx_data=0xA5, rx_ready=1, all errs 0, ready ~9.5 bit times after start edge.
//  7E1 0x41 parity=0 -> rx_data=0x41, parity_err=0; same with parity bit=1 -> parity_err=1, rx_data[7]=0.
//  8O1 0x00 with parity bit 1 -> parity_err=0; parity bit 0 -> parity_err=1.
//  rx low for 4 baud ticks then high -> FSM back to IDLE, rx_ready stays 0.
//  8N1 0x3C with stop bit low -> framing_err=1, rx_data=0x3C; read_rx_byte -> rx_ready=0, framing_err=0.
//  Frames 0x11 then 0x22 without read -> overflow=1, rx_data=0x22; reset asserted mid-DATA -> all outputs 0, next 0x5A received cleanly.

Source files
------------

// File: rtl/uart_rx_core.sv
// UART receive engine: 16x oversampled start detect, mid-bit sampling,
// 7/8 data bits, optional parity, stop check and ready/read handoff.
module uart_rx_core #(
  parameter int SYNC_STAGES = 2,
  parameter int MID_SAMPLE  = 7
) (
  input  logic       clk_sys,
  input  logic       rst_sys_n,
  input  logic       baud_clock,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       rx,
  input  logic       read_rx_byte,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic       rx_s;
  logic [3:0] samp_q, samp_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic       cfg8_q, cfg8_d;
  logic       cfgp_q, cfgp_d;
  logic       cfgo_q, cfgo_d;
  logic       perr_q, perr_d;
  logic       stop_q, stop_d;
  logic       store_q, store_d;
  logic [7:0] data_w;
  logic [2:0] last_bit;
  logic       mid;
  logic       tick_end;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign data_w   = cfg8_q ? shreg_q : {1'b0, shreg_q[7:1]};
  assign last_bit = cfg8_q ? 3'd7 : 3'd6;
  assign mid      = (samp_q == 4'(MID_SAMPLE));
  assign tick_end = (samp_q == 4'hf);

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q <= IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      cfg8_q  <= 1'b0;
      cfgp_q  <= 1'b0;
      cfgo_q  <= 1'b0;
      perr_q  <= 1'b0;
      stop_q  <= 1'b0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      cfg8_q  <= cfg8_d;
      cfgp_q  <= cfgp_d;
      cfgo_q  <= cfgo_d;
      perr_q  <= perr_d;
      stop_q  <= stop_d;
      store_q <= store_d;
    end
  end

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    cfg8_d  = cfg8_q;
    cfgp_d  = cfgp_q;
    cfgo_d  = cfgo_q;
    perr_d  = perr_q;
    stop_d  = stop_q;
    store_d = 1'b0;
    if (baud_clock) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            samp_d  = '0;
            cfg8_d  = bit8;
            cfgp_d  = parity_en;
            cfgo_d  = odd_n_even;
            perr_d  = 1'b0;
          end
        end
        START: begin
          if (mid) begin
            samp_d = '0;
            bit_d  = '0;
            // a start bit that went high again was only a glitch
            state_d = rx_s ? IDLE : DATA;
          end else begin
            samp_d = samp_q + 4'd1;
          end
        end
        DATA: begin
          samp_d = samp_q + 4'd1;
          if (tick_end) begin
            shreg_d = {rx_s, shreg_q[7:1]};
            if (bit_q == last_bit) begin
              state_d = cfgp_q ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
        PARITY: begin
          samp_d = samp_q + 4'd1;
          if (tick_end) begin
            perr_d  = ^data_w ^ rx_s ^ cfgo_q;
            state_d = STOP;
          end
        end
        STOP: begin
          samp_d = samp_q + 4'd1;
          if (tick_end) begin
            stop_d  = rx_s;
            store_d = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // store takes priority over a simultaneous read
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      rx_data     <= '0;
      rx_ready    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
    end else if (store_q) begin
      rx_data     <= data_w;
      rx_ready    <= 1'b1;
      parity_err  <= cfgp_q & perr_q;
      framing_err <= ~stop_q;
      overflow    <= rx_ready & ~read_rx_byte;
    end else if (read_rx_byte && rx_ready) begin
      rx_ready    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frame table plus glitch, overflow,
// break and mid-frame reset sequences.
module tb_uart_rx_core;

  logic       clk_sys = 1'b0;
  logic       rst_sys_n = 1'b0;
  logic       baud_clock = 1'b0;
  logic       bit8 = 1'b1;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic       rx = 1'b1;
  logic       read_rx_byte = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       parity_err;
  logic       framing_err;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int bcnt = 0;

  uart_rx_core #(.SYNC_STAGES(2), .MID_SAMPLE(7)) dut (
    .clk_sys     (clk_sys),
    .rst_sys_n   (rst_sys_n),
    .baud_clock  (baud_clock),
    .bit8        (bit8),
    .parity_en   (parity_en),
    .odd_n_even  (odd_n_even),
    .rx          (rx),
    .read_rx_byte(read_rx_byte),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .overflow    (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // one-cycle baud enable every 4 clocks
  always @(negedge clk_sys) begin
    bcnt = (bcnt + 1) % 4;
    baud_clock = (bcnt == 0);
  end

  typedef struct {
    string      name;
    logic [7:0] d;
    bit         b8;
    bit         pen;
    bit         odd;
    bit         pbit;
    bit         sbit;
    logic [7:0] ed;
    bit         ep;
    bit         ef;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put_bit(input logic b);
    rx = b;
    repeat (64) @(negedge clk_sys);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit b8,
                            input bit pen, input bit pbit,
                            input bit sbit, input bit chk_pre);
    put_bit(1'b0);
    for (int i = 0; i < (b8 ? 8 : 7); i++) put_bit(d[i]);
    if (pen) put_bit(pbit);
    if (chk_pre) chk("ready_before_stop", {7'd0, rx_ready}, 8'd0);
    if (sbit) begin
      put_bit(1'b1);
    end else begin
      rx = 1'b0;
      repeat (48) @(negedge clk_sys);
      rx = 1'b1;
      repeat (16) @(negedge clk_sys);
    end
    put_bit(1'b1);
  endtask

  task automatic do_read();
    read_rx_byte = 1'b1;
    @(negedge clk_sys);
    read_rx_byte = 1'b0;
    @(negedge clk_sys);
  endtask

  initial begin
    vecs[0] = '{"8N1_A5", 8'hA5, 1, 0, 0, 0, 1, 8'hA5, 0, 0};
    vecs[1] = '{"7E1_41_ok", 8'h41, 0, 1, 0, 0, 1, 8'h41, 0, 0};
    vecs[2] = '{"7E1_41_bad", 8'hC1, 0, 1, 0, 1, 1, 8'h41, 1, 0};
    vecs[3] = '{"8O1_00_ok", 8'h00, 1, 1, 1, 1, 1, 8'h00, 0, 0};
    vecs[4] = '{"8O1_00_bad", 8'h00, 1, 1, 1, 0, 1, 8'h00, 1, 0};
    vecs[5] = '{"8N1_3C_frm", 8'h3C, 1, 0, 0, 0, 0, 8'h3C, 0, 1};
    vecs[6] = '{"7O1_7F_ok", 8'h7F, 0, 1, 1, 0, 1, 8'h7F, 0, 0};
    vecs[7] = '{"8E1_FF_ok", 8'hFF, 1, 1, 0, 0, 1, 8'hFF, 0, 0};

    repeat (3) @(negedge clk_sys);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_ready", {7'd0, rx_ready}, 8'd0);
    chk("rst_flags", {5'd0, parity_err, framing_err, overflow}, 8'd0);
    rst_sys_n = 1'b1;
    repeat (40) @(negedge clk_sys);

    foreach (vecs[i]) begin
      bit8 = vecs[i].b8;
      parity_en = vecs[i].pen;
      odd_n_even = vecs[i].odd;
      send_frame(vecs[i].d, vecs[i].b8, vecs[i].pen, vecs[i].pbit,
                 vecs[i].sbit, 1'b1);
      chk({vecs[i].name, "_data"}, rx_data, vecs[i].ed);
      chk({vecs[i].name, "_ready"}, {7'd0, rx_ready}, 8'd1);
      chk({vecs[i].name, "_perr"}, {7'd0, parity_err}, {7'd0, vecs[i].ep});
      chk({vecs[i].name, "_ferr"}, {7'd0, framing_err}, {7'd0, vecs[i].ef});
      chk({vecs[i].name, "_ovf"}, {7'd0, overflow}, 8'd0);
      do_read();
      chk({vecs[i].name, "_rd_ready"}, {7'd0, rx_ready}, 8'd0);
      chk({vecs[i].name, "_rd_flags"},
          {5'd0, parity_err, framing_err, overflow}, 8'd0);
    end

    bit8 = 1'b1;
    parity_en = 1'b0;
    odd_n_even = 1'b0;

    rx = 1'b0;
    repeat (16) @(negedge clk_sys);
    rx = 1'b1;
    repeat (20 * 64) @(negedge clk_sys);
    chk("glitch_ready", {7'd0, rx_ready}, 8'd0);

    send_frame(8'h11, 1, 0, 0, 1, 1'b1);
    chk("ovf1_data", rx_data, 8'h11);
    chk("ovf1_ovf", {7'd0, overflow}, 8'd0);
    send_frame(8'h22, 1, 0, 0, 1, 1'b0);
    chk("ovf2_data", rx_data, 8'h22);
    chk("ovf2_ready", {7'd0, rx_ready}, 8'd1);
    chk("ovf2_ovf", {7'd0, overflow}, 8'd1);
    do_read();
    chk("ovf_rd_ovf", {7'd0, overflow}, 8'd0);
    chk("ovf_rd_ready", {7'd0, rx_ready}, 8'd0);

    rx = 1'b0;
    repeat (40 * 64) @(negedge clk_sys);
    chk("brk_data", rx_data, 8'h00);
    chk("brk_ready", {7'd0, rx_ready}, 8'd1);
    chk("brk_ferr", {7'd0, framing_err}, 8'd1);
    chk("brk_ovf", {7'd0, overflow}, 8'd1);
    rx = 1'b1;
    repeat (14 * 64) @(negedge clk_sys);
    do_read();
    chk("brk_rd_ready", {7'd0, rx_ready}, 8'd0);

    send_frame(8'h77, 1, 0, 0, 1, 1'b1);
    put_bit(1'b0);
    put_bit(1'b0);
    put_bit(1'b1);
    rst_sys_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_ready", {7'd0, rx_ready}, 8'd0);
    chk("mid_rst_flags", {5'd0, parity_err, framing_err, overflow}, 8'd0);
    rst_sys_n = 1'b1;
    repeat (64) @(negedge clk_sys);
    send_frame(8'h5A, 1, 0, 0, 1, 1'b1);
    chk("post_rst_data", rx_data, 8'h5A);
    chk("post_rst_ready", {7'd0, rx_ready}, 8'd1);
    chk("post_rst_flags", {5'd0, parity_err, framing_err, overflow}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
